alu_bit_serial: RTL
===================

# alu_bit_serial

Bit-serial N-bit ALU that evaluates one operation LSB-first over WIDTH clock cycles through a single 1-bit datapath slice. It uses the same 3-bit opcode set as the combinational ALU. Operands arrive on a valid/ready request port, and results leave on a valid/ready response port. It is the sequential execution engine that sits between an operation issuer and the register-file writeback, trading area for latency.

## Interface
- WIDTH, default 8: operand/result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock; only clock.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  3  opcode: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110 SLT, 111 reserved.
- r2  input  WIDTH  operand A (source).
- r3  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- r1  output  WIDTH  result.
- c_out  output  1  carry out of the adder; ADD/SUB only.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready, latch op, r2, r3 into internal registers, clear the bit counter, and move to RUN.
  - Carry register initialises to 1 for SUB/SLT and to 0 otherwise.
- RUN: one bit per cycle, bit i = counter value, LSB first.
  - Slice computes res_i and next carry from a_i, b_i and carry; for SUB/SLT, b_i is inverted.
  - res_i shifts into the result register from the MSB side.
  - The counter increments; after bit WIDTH-1 the state moves to DONE.
- Per-bit functions:
  - MOV: a.
  - NOT: ~a.
  - ADD: a^b^c.
  - SUB: a^~b^c.
  - OR: a|b.
  - AND: a&b.
  - SLT: difference bits computed, not stored.
  - 111: 0.
- c_out = final carry for ADD/SUB; for SUB, c_out=1 means r2≥r3 unsigned; c_out=0 for all other ops.
- SLT: r1 = {WIDTH-1 zeros, less}, where less = sign(r2−r3) XOR overflow. Overflow = carry into MSB XOR carry out of MSB, taken on the final RUN cycle. The result is a signed comparison.
- DONE: out_valid=1, in_ready=0, and r1/c_out are held stable.
  - On out_valid&&out_ready, move to IDLE.
- Input changes on r2/r3/op outside the accept edge have no effect.
- in_valid while in_ready=0 is ignored and is not queued.
- Arithmetic is modulo 2^WIDTH; no overflow flag is exported.

## Timing
- Reset (rst_n=0 at a clk edge) forces the following after that edge, regardless of state:
  - state=IDLE, in_ready=1, out_valid=0, r1=0, c_out=0.
  - Counter, carry and operand registers are cleared.
- Reset mid-RUN or mid-DONE discards the operation; no out_valid is produced for it.
- in_ready and out_valid are decoded from registered state, with no combinational path from inputs.
- Latency: if the request is accepted at edge E0, out_valid is high after edge E0+WIDTH.
- Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE with out_ready=1).
- A request cannot be accepted in the same cycle as a DONE handshake. in_ready rises only after the edge that completes the response.
- out_ready held low keeps DONE indefinitely; r1/c_out do not change.
- r1 is undefined-but-stable during RUN (partial shift contents). Consumers must only sample it when out_valid=1.

## Test plan
- WIDTH=8, ADD r2=0xFF r3=0x01 -> r1=0x00, c_out=1, out_valid exactly 8 edges after accept; ADD 0x12+0x34 -> 0x46, c_out=0.
- SUB 0x05−0x07 -> r1=0xFE, c_out=0; SUB 0x07−0x05 -> r1=0x02, c_out=1; SUB 0x00−0x00 -> 0x00, c_out=1.
- SLT (0x80,0x01) -> 0x01; (0x01,0x80) -> 0x00; (0x7F,0x80) -> 0x00 (overflow path); (0x80,0x7F) -> 0x01; (0x33,0x33) -> 0x00; c_out=0 throughout.
- Logic ops:
  - MOV 0xA5 -> 0xA5; NOT 0xA5 -> 0x5A; OR 0xA0|0x05 -> 0xA5; AND 0xF0&0x3C -> 0x30; op=111 -> 0x00.
  - Every result is scoreboarded against a golden behavioral ALU model.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and r2/r3 -> r1/c_out stable, in_ready=0, no new accept.
  - Then out_ready=1 -> IDLE next edge, in_ready=1.
- Reset on the 4th RUN cycle (rst_n low for one edge) -> out_valid never asserts for that op, outputs zero, in_ready=1; the next ADD 0x0F+0x01 returns 0x10.

Source files
------------

// File: rtl/alu_bit_serial_if.sv
// Request/response handshake bundle for the bit-serial ALU.
// The issuer drives the request side and consumes the response side.
interface alu_bit_serial_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] r2;
   logic [WIDTH-1:0] r3;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r1;
   logic             c_out;

   modport master (
      output in_valid, op, r2, r3, out_ready,
      input  in_ready, out_valid, r1, c_out
   );

   modport slave (
      input  in_valid, op, r2, r3, out_ready,
      output in_ready, out_valid, r1, c_out
   );
endinterface

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: one operation evaluated LSB-first through a 1-bit slice
// over WIDTH cycles, with valid/ready request and response handshakes.
module alu_bit_serial #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   alu_bit_serial_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [2:0] OP_MOV = 3'b000;
   localparam logic [2:0] OP_NOT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state, state_nxt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q, cout_q;
   logic             sub_mode, b_bit, sum_bit, carry_nxt, res_bit, last_bit, less;

   function automatic logic slice_res(input logic [2:0] op, input logic a,
                                      input logic b, input logic sum);
      logic r;
      case (op)
         OP_MOV:          r = a;
         OP_NOT:          r = ~a;
         OP_ADD, OP_SUB:  r = sum;
         OP_OR:           r = a | b;
         OP_AND:          r = a & b;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

   // Operands shift right each RUN cycle, so bit 0 is always the live bit.
   assign sub_mode  = (op_q == OP_SUB) || (op_q == OP_SLT);
   assign b_bit     = b_q[0] ^ sub_mode;
   assign sum_bit   = a_q[0] ^ b_bit ^ carry_q;
   assign carry_nxt = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
   assign res_bit   = slice_res(op_q, a_q[0], b_q[0], sum_bit);
   assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
   // Signed less-than: MSB of difference XOR (carry into MSB ^ carry out of MSB).
   assign less      = sum_bit ^ carry_q ^ carry_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op_q    <= bus.op;
                  a_q     <= bus.r2;
                  b_q     <= bus.r3;
                  cnt_q   <= '0;
                  carry_q <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
                  cout_q  <= 1'b0;
               end
            end
            RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_nxt;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_bit && op_q == OP_SLT)
                  res_q <= {{(WIDTH-1){1'b0}}, less};
               else
                  res_q <= {res_bit, res_q[WIDTH-1:1]};
               if (last_bit)
                  cout_q <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? carry_nxt : 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.r1    = res_q;
   assign bus.c_out = cout_q;
endmodule
